// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing helpers for the credit-gated FIFO reader.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  // Counter width able to hold the value CREDITS itself.
  function automatic int unsigned credit_bits(input int unsigned credits);
    return $clog2(credits) + 1;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit pool: applies issue and return in the same cycle, clamps overflow to CREDITS
// and latches a sticky error on any return that would exceed the pool.
module credit_counter
  import fifo_reader_pkg::*;
#(
  parameter int unsigned CREDITS     = 64,
  parameter int unsigned CREDIT_BITS = credit_bits(CREDITS)
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   issue,
  input  logic                   ret_valid,
  input  logic [CREDIT_BITS-1:0] ret_count,
  output logic [CREDIT_BITS-1:0] credits,
  output logic                   credit_err,
  output logic [CREDIT_BITS-1:0] credits_nxt_c
);

  localparam int unsigned SUM_BITS = CREDIT_BITS + 1;
  localparam logic [SUM_BITS-1:0] MAX_SUM = SUM_BITS'(CREDITS);

  logic [SUM_BITS-1:0] sum_c;
  logic                over_c;

  // Extra bit so an oversized return is detected rather than wrapping.
  always_comb begin
    sum_c = SUM_BITS'(credits) - SUM_BITS'(issue);
    if (ret_valid) begin
      sum_c = sum_c + SUM_BITS'(ret_count);
    end
    over_c        = (sum_c > MAX_SUM);
    credits_nxt_c = over_c ? CREDIT_BITS'(CREDITS) : sum_c[CREDIT_BITS-1:0];
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      credits    <= CREDIT_BITS'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      credits <= credits_nxt_c;
      if (over_c) begin
        credit_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_credit_reader.sv
// Pops a sync FIFO and issues one-cycle command pulses while credits remain;
// tracks drain status so the job FSM knows when every command has retired.
module fifo_credit_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CREDITS     = 64,
  parameter int unsigned CREDIT_BITS = credit_bits(CREDITS),
  parameter int unsigned CNT_BITS    = 32
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   fifo_valid,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_pop,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   credit_ret_valid,
  input  logic [CREDIT_BITS-1:0] credit_ret_count,
  output logic [CREDIT_BITS-1:0] credits,
  output logic                   busy,
  output logic                   drained,
  output logic                   credit_err,
  output logic [CNT_BITS-1:0]    issued_count
);

  reader_state_t          state, state_nxt;
  logic [CREDIT_BITS-1:0] credits_nxt_c;

  credit_counter #(
    .CREDITS    (CREDITS),
    .CREDIT_BITS(CREDIT_BITS)
  ) u_credit_counter (
    .clock        (clock),
    .rstn         (rstn),
    .issue        (fifo_pop),
    .ret_valid    (credit_ret_valid),
    .ret_count    (credit_ret_count),
    .credits      (credits),
    .credit_err   (credit_err),
    .credits_nxt_c(credits_nxt_c)
  );

  // Pop gate uses only registered credits; a same-cycle return helps next cycle.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        fifo_pop = enable && fifo_valid && (credits != '0) && !credit_err;
        if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (enable) begin
          state_nxt = RUN;
        end else if (credits_nxt_c == CREDIT_BITS'(CREDITS)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      drained      <= 1'b1;
      issued_count <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= fifo_pop;
      out_data  <= fifo_pop ? fifo_data : '0;
      busy      <= (state_nxt != IDLE);
      drained   <= (state_nxt == IDLE) && (credits_nxt_c == CREDIT_BITS'(CREDITS));
      if (fifo_pop) begin
        issued_count <= issued_count + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_credit_reader.sv
// Directed bench for fifo_credit_reader: a 64-credit instance and a 4-credit instance.
module tb_fifo_credit_reader;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned CREDITS_A = 64;
  localparam int unsigned CB_A      = 7;
  localparam int unsigned CREDITS_B = 4;
  localparam int unsigned CB_B      = 3;
  localparam int unsigned CNT_BITS  = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rstn;

  logic                enable_a, fifo_valid_a, fifo_pop_a, out_valid_a;
  logic                ret_valid_a, busy_a, drained_a, err_a;
  logic [WIDTH-1:0]    fifo_data_a, out_data_a;
  logic [CB_A-1:0]     ret_count_a, credits_a;
  logic [CNT_BITS-1:0] issued_a;

  logic                enable_b, fifo_valid_b, fifo_pop_b, out_valid_b;
  logic                ret_valid_b, busy_b, drained_b, err_b;
  logic [WIDTH-1:0]    fifo_data_b, out_data_b;
  logic [CB_B-1:0]     ret_count_b, credits_b;
  logic [CNT_BITS-1:0] issued_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Simple FIFO models: pushes from the initial block, pops on the DUT request.
  logic [WIDTH-1:0] mem_a [128];
  logic [WIDTH-1:0] mem_b [128];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

  assign fifo_valid_a = (wr_a != rd_a);
  assign fifo_data_a  = fifo_valid_a ? mem_a[7'(rd_a)] : '0;
  assign fifo_valid_b = (wr_b != rd_b);
  assign fifo_data_b  = fifo_valid_b ? mem_b[7'(rd_b)] : '0;

  always @(posedge clock) begin
    if (fifo_pop_a && fifo_valid_a) rd_a <= rd_a + 1;
    if (fifo_pop_b && fifo_valid_b) rd_b <= rd_b + 1;
  end

  fifo_credit_reader #(
    .WIDTH(WIDTH), .CREDITS(CREDITS_A), .CREDIT_BITS(CB_A), .CNT_BITS(CNT_BITS)
  ) u_dut_a (
    .clock(clock), .rstn(rstn), .enable(enable_a),
    .fifo_valid(fifo_valid_a), .fifo_data(fifo_data_a), .fifo_pop(fifo_pop_a),
    .out_valid(out_valid_a), .out_data(out_data_a),
    .credit_ret_valid(ret_valid_a), .credit_ret_count(ret_count_a),
    .credits(credits_a), .busy(busy_a), .drained(drained_a),
    .credit_err(err_a), .issued_count(issued_a)
  );

  fifo_credit_reader #(
    .WIDTH(WIDTH), .CREDITS(CREDITS_B), .CREDIT_BITS(CB_B), .CNT_BITS(CNT_BITS)
  ) u_dut_b (
    .clock(clock), .rstn(rstn), .enable(enable_b),
    .fifo_valid(fifo_valid_b), .fifo_data(fifo_data_b), .fifo_pop(fifo_pop_b),
    .out_valid(out_valid_b), .out_data(out_data_b),
    .credit_ret_valid(ret_valid_b), .credit_ret_count(ret_count_b),
    .credits(credits_b), .busy(busy_b), .drained(drained_b),
    .credit_err(err_b), .issued_count(issued_b)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_a(input logic [WIDTH-1:0] d);
    mem_a[7'(wr_a)] = d;
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [WIDTH-1:0] d);
    mem_b[7'(wr_b)] = d;
    wr_b = wr_b + 1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
    ret_valid_a = 1'b0; ret_count_a = '0; ret_valid_b = 1'b0; ret_count_b = '0;
    step(2);
    n_checks++; if (fifo_pop_a !== 1'b0) $display("FAIL reset_pop: got %0d exp 0", fifo_pop_a); else n_pass++;
    n_checks++; if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid: got %0d exp 0", out_valid_a); else n_pass++;
    n_checks++; if (out_data_a !== 32'h0) $display("FAIL reset_out_data: got %0h exp 0", out_data_a); else n_pass++;
    n_checks++; if (credits_a !== 7'd64) $display("FAIL reset_credits: got %0d exp 64", credits_a); else n_pass++;
    n_checks++; if (err_a !== 1'b0) $display("FAIL reset_err: got %0d exp 0", err_a); else n_pass++;
    n_checks++; if (issued_a !== 32'd0) $display("FAIL reset_issued: got %0d exp 0", issued_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %0d exp 0", busy_a); else n_pass++;
    n_checks++; if (drained_a !== 1'b1) $display("FAIL reset_drained: got %0d exp 1", drained_a); else n_pass++;
    n_checks++; if (credits_b !== 3'd4) $display("FAIL reset_credits_b: got %0d exp 4", credits_b); else n_pass++;
    rstn = 1'b1;
  endtask

  task automatic test_credit_limit();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 6; i++) push_b(32'h10 + 32'(i));
    enable_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (out_valid_b) pulses++;
    end
    n_checks++; if (pulses != 4) $display("FAIL limit_pulses: got %0d exp 4", pulses); else n_pass++;
    n_checks++; if (credits_b !== 3'd0) $display("FAIL limit_credits: got %0d exp 0", credits_b); else n_pass++;
    n_checks++; if (issued_b !== 32'd4) $display("FAIL limit_issued: got %0d exp 4", issued_b); else n_pass++;
    n_checks++; if (fifo_pop_b !== 1'b0 || fifo_valid_b !== 1'b1)
      $display("FAIL limit_stall: got pop=%0d valid=%0d exp pop=0 valid=1", fifo_pop_b, fifo_valid_b); else n_pass++;
    ret_valid_b = 1'b1; ret_count_b = 3'd2;
    #1;
    n_checks++; if (fifo_pop_b !== 1'b0) $display("FAIL limit_ret_same_cycle: got %0d exp 0", fifo_pop_b); else n_pass++;
    step(1);
    ret_valid_b = 1'b0; ret_count_b = '0;
    #1;
    n_checks++; if (fifo_pop_b !== 1'b1) $display("FAIL limit_ret_next_cycle: got %0d exp 1", fifo_pop_b); else n_pass++;
    step(1);
    n_checks++; if (out_valid_b !== 1'b1 || out_data_b !== 32'h14)
      $display("FAIL limit_data5: got v=%0d d=%0h exp v=1 d=14", out_valid_b, out_data_b); else n_pass++;
    step(1);
    n_checks++; if (out_valid_b !== 1'b1 || out_data_b !== 32'h15)
      $display("FAIL limit_data6: got v=%0d d=%0h exp v=1 d=15", out_valid_b, out_data_b); else n_pass++;
    n_checks++; if (credits_b !== 3'd0 || issued_b !== 32'd6)
      $display("FAIL limit_final: got credits=%0d issued=%0d exp 0/6", credits_b, issued_b); else n_pass++;
    enable_b = 1'b0;
  endtask

  task automatic test_issue();
    logic [WIDTH-1:0] exp_d [3];
    exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
    for (int i = 0; i < 3; i++) push_a(exp_d[i]);
    enable_a = 1'b1;
    step(1);
    n_checks++; if (fifo_pop_a !== 1'b1 || out_valid_a !== 1'b0)
      $display("FAIL issue_first_pop: got pop=%0d v=%0d exp pop=1 v=0", fifo_pop_a, out_valid_a); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== exp_d[i])
        $display("FAIL issue_data%0d: got v=%0d d=%0h exp v=1 d=%0h", i, out_valid_a, out_data_a, exp_d[i]); else n_pass++;
    end
    step(1);
    n_checks++; if (out_valid_a !== 1'b0) $display("FAIL issue_end_valid: got %0d exp 0", out_valid_a); else n_pass++;
    n_checks++; if (credits_a !== 7'd61) $display("FAIL issue_credits: got %0d exp 61", credits_a); else n_pass++;
    n_checks++; if (issued_a !== 32'd3) $display("FAIL issue_count: got %0d exp 3", issued_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b1 || drained_a !== 1'b0)
      $display("FAIL issue_status: got busy=%0d drained=%0d exp 1/0", busy_a, drained_a); else n_pass++;
  endtask

  task automatic test_drain();
    push_a(32'hD); push_a(32'hE);
    step(3);
    n_checks++; if (credits_a !== 7'd59) $display("FAIL drain_pre_credits: got %0d exp 59", credits_a); else n_pass++;
    enable_a = 1'b0;
    step(1);
    n_checks++; if (busy_a !== 1'b1 || drained_a !== 1'b0)
      $display("FAIL drain_status: got busy=%0d drained=%0d exp 1/0", busy_a, drained_a); else n_pass++;
    push_a(32'hF);
    #1;
    n_checks++; if (fifo_pop_a !== 1'b0) $display("FAIL drain_no_pop: got %0d exp 0", fifo_pop_a); else n_pass++;
    ret_valid_a = 1'b1; ret_count_a = 7'd5;
    step(1);
    ret_valid_a = 1'b0; ret_count_a = '0;
    n_checks++; if (busy_a !== 1'b0 || drained_a !== 1'b1)
      $display("FAIL drain_idle: got busy=%0d drained=%0d exp 0/1", busy_a, drained_a); else n_pass++;
    n_checks++; if (credits_a !== 7'd64) $display("FAIL drain_credits: got %0d exp 64", credits_a); else n_pass++;
    n_checks++; if (issued_a !== 32'd5) $display("FAIL drain_issued: got %0d exp 5", issued_a); else n_pass++;
    wr_a = rd_a;
  endtask

  task automatic test_same_cycle();
    enable_a = 1'b1;
    for (int i = 0; i < 54; i++) push_a(32'h100 + 32'(i));
    step(60);
    n_checks++; if (credits_a !== 7'd10) $display("FAIL same_pre_credits: got %0d exp 10", credits_a); else n_pass++;
    push_a(32'h77);
    ret_valid_a = 1'b1; ret_count_a = 7'd1;
    #1;
    n_checks++; if (fifo_pop_a !== 1'b1) $display("FAIL same_pop: got %0d exp 1", fifo_pop_a); else n_pass++;
    step(1);
    ret_valid_a = 1'b0; ret_count_a = '0;
    n_checks++; if (credits_a !== 7'd10) $display("FAIL same_credits: got %0d exp 10", credits_a); else n_pass++;
    n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== 32'h77)
      $display("FAIL same_data: got v=%0d d=%0h exp v=1 d=77", out_valid_a, out_data_a); else n_pass++;
    for (int i = 0; i < 10; i++) push_a(32'h200 + 32'(i));
    step(15);
    n_checks++; if (credits_a !== 7'd0 || issued_a !== 32'd70)
      $display("FAIL zero_credits: got credits=%0d issued=%0d exp 0/70", credits_a, issued_a); else n_pass++;
    push_a(32'h99);
    ret_valid_a = 1'b1; ret_count_a = 7'd1;
    #1;
    n_checks++; if (fifo_pop_a !== 1'b0) $display("FAIL zero_blocked: got %0d exp 0", fifo_pop_a); else n_pass++;
    step(1);
    ret_valid_a = 1'b0; ret_count_a = '0;
    #1;
    n_checks++; if (credits_a !== 7'd1 || fifo_pop_a !== 1'b1)
      $display("FAIL zero_unblock: got credits=%0d pop=%0d exp 1/1", credits_a, fifo_pop_a); else n_pass++;
    step(1);
    n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== 32'h99 || credits_a !== 7'd0)
      $display("FAIL zero_issue: got v=%0d d=%0h c=%0d exp 1/99/0", out_valid_a, out_data_a, credits_a); else n_pass++;
  endtask

  task automatic test_credit_err();
    ret_valid_a = 1'b1; ret_count_a = 7'd63;
    step(1);
    ret_valid_a = 1'b0; ret_count_a = '0;
    n_checks++; if (credits_a !== 7'd63 || err_a !== 1'b0)
      $display("FAIL err_pre: got credits=%0d err=%0d exp 63/0", credits_a, err_a); else n_pass++;
    ret_valid_a = 1'b1; ret_count_a = 7'd3;
    step(1);
    ret_valid_a = 1'b0; ret_count_a = '0;
    n_checks++; if (err_a !== 1'b1 || credits_a !== 7'd64)
      $display("FAIL err_set: got err=%0d credits=%0d exp 1/64", err_a, credits_a); else n_pass++;
    push_a(32'h55);
    #1;
    n_checks++; if (fifo_pop_a !== 1'b0) $display("FAIL err_halt_pop: got %0d exp 0", fifo_pop_a); else n_pass++;
    step(1);
    n_checks++; if (out_valid_a !== 1'b0 || err_a !== 1'b1)
      $display("FAIL err_sticky: got v=%0d err=%0d exp 0/1", out_valid_a, err_a); else n_pass++;
    enable_a = 1'b0;
    rstn = 1'b0;
    step(1);
    n_checks++; if (err_a !== 1'b0 || credits_a !== 7'd64)
      $display("FAIL err_clear: got err=%0d credits=%0d exp 0/64", err_a, credits_a); else n_pass++;
    rstn = 1'b1;
    wr_a = rd_a;
  endtask

  task automatic test_reset_mid();
    enable_a = 1'b1;
    push_a(32'h1A); push_a(32'h2B);
    step(2);
    n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== 32'h1A)
      $display("FAIL mid_pre: got v=%0d d=%0h exp 1/1a", out_valid_a, out_data_a); else n_pass++;
    rstn = 1'b0;
    step(1);
    n_checks++; if (out_valid_a !== 1'b0) $display("FAIL mid_out_valid: got %0d exp 0", out_valid_a); else n_pass++;
    n_checks++; if (credits_a !== 7'd64) $display("FAIL mid_credits: got %0d exp 64", credits_a); else n_pass++;
    n_checks++; if (issued_a !== 32'd0) $display("FAIL mid_issued: got %0d exp 0", issued_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || drained_a !== 1'b1)
      $display("FAIL mid_idle: got busy=%0d drained=%0d exp 0/1", busy_a, drained_a); else n_pass++;
    enable_a = 1'b0;
    rstn = 1'b1;
    wr_a = rd_a;
    step(1);
  endtask

  initial begin
    test_reset();
    test_credit_limit();
    test_issue();
    test_drain();
    test_same_cycle();
    test_credit_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
